// File: rtl/draw_rect_ctl_bounce.sv
// rtl/draw_rect_ctl_bounce.sv - mouse-released rectangle that falls, bounces on the floor and comes to rest
//
// Purpose: while idle the rectangle follows the mouse (clamped to the screen).
// A left click releases it. It then falls under constant gravity and rebounds
// off the floor, losing energy on each bounce, until the rebound is too weak
// and it comes to rest. A further click returns it to mouse tracking.
//
// Ports:
//   clk          in   pixel clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   mouse_left   in   left button level
//   mouse_xpos   in   [11:0] mouse x
//   mouse_ypos   in   [11:0] mouse y
//   xpos         out  [11:0] rectangle top-left x, registered
//   ypos         out  [11:0] rectangle top-left y, registered
//   state        out  [1:0]  IDLE=0, FALL=1, RISE=2, REST=3
//   step         out  one-cycle pulse on each physics step
//
// Build option: define DRAW_RECT_CTL_SYNC_EN to pass mouse_left through a
// two-flop synchroniser before edge detection (adds 2 clk of click latency).

module draw_rect_ctl_bounce #(
  parameter int X_MAX        = 800,
  parameter int Y_MAX        = 600,
  parameter int RECT_W       = 48,
  parameter int RECT_H       = 64,
  parameter int TICK_DIV     = 400000,
  parameter int GRAVITY      = 1,
  parameter int V_MAX        = 40,
  parameter int BOUNCE_SHIFT = 2,
  parameter int V_MIN        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [1:0]  state,
  output logic        step
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [11:0] FLOOR = 12'(Y_MAX - RECT_H);
  localparam logic [11:0] XLIM  = 12'(X_MAX - RECT_W);
  localparam logic [11:0] GRAV  = 12'(GRAVITY);
  localparam logic [11:0] VMAX  = 12'(V_MAX);
  localparam logic [11:0] VMIN  = 12'(V_MIN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FALL = 2'd1, RISE = 2'd2, REST = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [11:0]       x_q, x_d, y_q, y_d, v_q, v_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              step_q, step_d;
  logic              btn_q;
  logic              btn;

`ifdef DRAW_RECT_CTL_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], mouse_left};
  end
  assign btn = sync_q[1];
`else
  assign btn = mouse_left;
`endif

  logic        click, moving, tick_wrap, floor_hit, weak_rebound;
  logic [12:0] y_sum, v_inc;
  logic [11:0] rebound, mx_clamp, my_clamp;

  assign click        = btn & ~btn_q;
  assign moving       = (state_q == FALL) || (state_q == RISE);
  assign tick_wrap    = moving && (cnt_q == CNT_LAST);
  // 13-bit sum so a fast fall near the bottom cannot wrap past the floor test
  assign y_sum        = {1'b0, y_q} + {1'b0, v_q};
  assign v_inc        = {1'b0, v_q} + {1'b0, GRAV};
  assign floor_hit    = y_sum >= {1'b0, FLOOR};
  assign rebound      = v_q - (v_q >> BOUNCE_SHIFT);
  assign weak_rebound = rebound < VMIN;
  assign mx_clamp     = (mouse_xpos > XLIM)  ? XLIM  : mouse_xpos;
  assign my_clamp     = (mouse_ypos > FLOOR) ? FLOOR : mouse_ypos;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      v_q     <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      btn_q   <= btn;
    end
  end

  // Next-state logic: motion states change only on a physics step,
  // IDLE and REST change only on a click edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (click) state_d = FALL;
      FALL: if (tick_wrap && floor_hit) state_d = weak_rebound ? REST : RISE;
      RISE: if (tick_wrap && (v_q <= GRAV)) state_d = FALL;
      REST: if (click) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    v_d    = v_q;
    cnt_d  = cnt_q;
    step_d = 1'b0;
    case (state_q)
      IDLE: begin
        x_d = mx_clamp;
        y_d = my_clamp;
        if (click) begin
          v_d   = '0;
          cnt_d = '0;
        end
      end
      FALL: begin
        cnt_d = tick_wrap ? '0 : cnt_q + 1'b1;
        if (tick_wrap) begin
          step_d = 1'b1;
          if (floor_hit) begin
            y_d = FLOOR;
            v_d = weak_rebound ? 12'd0 : rebound;
          end else begin
            y_d = y_sum[11:0];
            v_d = (v_inc > {1'b0, VMAX}) ? VMAX : v_inc[11:0];
          end
        end
      end
      RISE: begin
        cnt_d = tick_wrap ? '0 : cnt_q + 1'b1;
        if (tick_wrap) begin
          step_d = 1'b1;
          y_d    = (y_q > v_q) ? y_q - v_q : 12'd0;
          v_d    = (v_q <= GRAV) ? 12'd0 : v_q - GRAV;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    xpos  = x_q;
    ypos  = y_q;
    state = state_q;
    step  = step_q;
  end

endmodule

// File: tb/tb_draw_rect_ctl_bounce.sv
// tb/tb_draw_rect_ctl_bounce.sv - self-checking bench for draw_rect_ctl_bounce against a signed-velocity model

module tb_draw_rect_ctl_bounce;

  localparam int X_MAX        = 800;
  localparam int Y_MAX        = 600;
  localparam int RECT_W       = 48;
  localparam int RECT_H       = 64;
  localparam int TICK_DIV     = 4;
  localparam int GRAVITY      = 1;
  localparam int V_MAX        = 40;
  localparam int BOUNCE_SHIFT = 1;
  localparam int V_MIN        = 2;
  localparam int FLOOR        = Y_MAX - RECT_H;
  localparam int XLIM         = X_MAX - RECT_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_xpos = '0;
  logic [11:0] mouse_ypos = '0;
  logic [11:0] xpos, ypos;
  logic [1:0]  state;
  logic        step;

  draw_rect_ctl_bounce #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .RECT_W(RECT_W), .RECT_H(RECT_H),
    .TICK_DIV(TICK_DIV), .GRAVITY(GRAVITY), .V_MAX(V_MAX),
    .BOUNCE_SHIFT(BOUNCE_SHIFT), .V_MIN(V_MIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .xpos(xpos), .ypos(ypos), .state(state), .step(step)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: velocity is signed (positive = downward), one phase
  // counter since launch, physics applied once every TICK_DIV clocks.
  bit m_moving, m_resting, m_prev, m_step;
  int m_x, m_y, m_s, m_cyc;
  int step_y[$];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset();
    m_moving = 0; m_resting = 0; m_prev = 0; m_step = 0;
    m_x = 0; m_y = 0; m_s = 0; m_cyc = 0;
  endfunction

  function automatic void physics();
    int ny, r, up;
    if (m_s >= 0) begin
      ny = m_y + m_s;
      if (ny >= FLOOR) begin
        m_y = FLOOR;
        r = m_s - m_s / (1 << BOUNCE_SHIFT);
        if (r < V_MIN) begin
          m_s = 0; m_moving = 0; m_resting = 1;
        end else begin
          m_s = -r;
        end
      end else begin
        m_y = ny;
        m_s = imin(m_s + GRAVITY, V_MAX);
      end
    end else begin
      up  = -m_s;
      m_y = (m_y - up > 0) ? m_y - up : 0;
      m_s = (up <= GRAVITY) ? 0 : -(up - GRAVITY);
    end
  endfunction

  function automatic void model_clock();
    bit click;
    click  = mouse_left && !m_prev;
    m_prev = mouse_left;
    m_step = 0;
    if (m_moving) begin
      m_cyc++;
      if (m_cyc == TICK_DIV) begin
        m_cyc  = 0;
        m_step = 1;
        physics();
      end
    end else if (m_resting) begin
      if (click) m_resting = 0;
    end else begin
      m_x = imin(int'(mouse_xpos), XLIM);
      m_y = imin(int'(mouse_ypos), FLOOR);
      if (click) begin
        m_s = 0; m_cyc = 0; m_moving = 1;
      end
    end
  endfunction

  function automatic int exp_state();
    if (m_resting) return 3;
    if (!m_moving) return 0;
    return (m_s < 0) ? 2 : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_clock();
    #1;
    check("xpos", int'(xpos), m_x);
    check("ypos", int'(ypos), m_y);
    check("state", int'(state), exp_state());
    check("step", int'(step), int'(m_step));
    if (step) step_y.push_back(int'(ypos));
  endtask

  task automatic click();
    mouse_left = 1'b1; tick();
    mouse_left = 1'b0; tick();
  endtask

  task automatic wait_rest(input string tag);
    int k = 0;
    while (state != 2'd3 && k < 3000) begin tick(); k++; end
    check(tag, int'(state), 3);
  endtask

  task automatic wait_steps(input int n, input string tag);
    int k = 0;
    while (step_y.size() < n && k < 200) begin tick(); k++; end
    check(tag, step_y.size(), n);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int launch_exp[4];
    int bounce_exp[6];
    launch_exp = '{0, 1, 3, 6};
    bounce_exp = '{530, 531, 533, 536, 534, 533};
    model_reset();

    // Reset
    tick(); tick();
    check("rst_xpos", int'(xpos), 0);
    check("rst_ypos", int'(ypos), 0);
    check("rst_state", int'(state), 0);
    check("rst_step", int'(step), 0);
    rst_n = 1'b1;

    // Tracking with clamping
    mouse_xpos = 12'd900; mouse_ypos = 12'd700;
    tick();
    check("track_x", int'(xpos), 752);
    check("track_y", int'(ypos), 536);

    // Launch from the top
    mouse_xpos = 12'd100; mouse_ypos = 12'd0;
    tick();
    mouse_left = 1'b1; tick();
    check("launch_state", int'(state), 1);
    mouse_left = 1'b0;
    step_y.delete();
    wait_steps(4, "launch_steps");
    for (int i = 0; i < 4 && i < step_y.size(); i++)
      check($sformatf("launch_y%0d", i), step_y[i], launch_exp[i]);
    check("launch_x", int'(xpos), 100);

    // Click during the fall is ignored
    click();
    check("ignored_click_state", int'(state), 1);
    wait_rest("rest_after_launch");
    check("rest_y", int'(ypos), FLOOR);

    // REST exit, held button does not relaunch
    mouse_xpos = 12'd200; mouse_ypos = 12'd300;
    mouse_left = 1'b1; tick();
    check("rest_exit_state", int'(state), 0);
    for (int i = 0; i < 10; i++) tick();
    check("held_state", int'(state), 0);
    check("held_track_x", int'(xpos), 200);
    mouse_left = 1'b0; tick();
    mouse_left = 1'b1; tick();
    check("relaunch_state", int'(state), 1);
    mouse_left = 1'b0;
    wait_rest("rest_after_relaunch");

    // Bounce near the floor
    click();
    mouse_xpos = 12'd50; mouse_ypos = 12'd530;
    tick();
    mouse_left = 1'b1; tick();
    mouse_left = 1'b0;
    step_y.delete();
    wait_steps(6, "bounce_steps");
    for (int i = 0; i < 6 && i < step_y.size(); i++)
      check($sformatf("bounce_y%0d", i), step_y[i], bounce_exp[i]);
    wait_rest("bounce_rest");
    check("bounce_rest_y", int'(ypos), 536);

    // Asynchronous reset mid-fall
    click();
    mouse_xpos = 12'd10; mouse_ypos = 12'd100;
    tick();
    click();
    for (int i = 0; i < 6; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_ypos", int'(ypos), 0);
    check("async_rst_xpos", int'(xpos), 0);
    model_reset();
    tick(); tick();
    rst_n = 1'b1;

    // Randomized mouse movement and clicks
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        mouse_xpos = 12'($urandom_range(0, 4095));
        mouse_ypos = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 600))
                                                 : 12'($urandom_range(0, 4095));
      end
      if ($urandom_range(0, 39) == 0) mouse_left = ~mouse_left;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/draw_rect_ctl_bounce.md
# draw_rect_ctl_bounce

Parametrised successor to the falling-rectangle controller in the VGA mouse-drawing path. While idle, the rectangle follows the mouse. A left click releases it from the current mouse position. It then falls under constant gravity and bounces on the screen floor, losing energy on each bounce, until it comes to rest. Its `xpos`/`ypos` drive the rectangle drawer downstream of the mouse control block in the 40 MHz pixel-clock domain.

## Interface
- `X_MAX`, 800, visible width in pixels
- `Y_MAX`, 600, visible height in pixels
- `RECT_W`, 48, rectangle width
- `RECT_H`, 64, rectangle height
- `TICK_DIV`, 400000, clk cycles per physics step (100 Hz at 40 MHz); must be ≥ 2
- `GRAVITY`, 1, velocity increment per step (px/step)
- `V_MAX`, 40, velocity saturation value
- `BOUNCE_SHIFT`, 2, rebound loss: `v_new = v - (v >> BOUNCE_SHIFT)`
- `V_MIN`, 2, rebound velocity below which the block stops
- `clk`  in  1  pixel clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mouse_left`  in  1  left button level
- `mouse_xpos`  in  12  mouse x
- `mouse_ypos`  in  12  mouse y
- `xpos`  out  12  rectangle top-left x, registered
- `ypos`  out  12  rectangle top-left y, registered
- `state`  out  2  IDLE=0, FALL=1, RISE=2, REST=3
- `step`  out  1  one-cycle pulse on each physics step

## Operation
- `FLOOR = Y_MAX - RECT_H`; `XLIM = X_MAX - RECT_W`.
- Velocity `v` is an internal 12-bit unsigned value; there is no negative arithmetic. Direction is implied by the state.
- Click = rising edge of `mouse_left`, detected against a registered copy of the button level.
- IDLE:
  - `xpos <= min(mouse_xpos, XLIM)`, `ypos <= min(mouse_ypos, FLOOR)`.
  - On click: the position registers take that cycle's clamped mouse values, `v <= 0`, tick counter cleared, state goes to FALL.
- The tick counter runs only in FALL and RISE. It counts 0..TICK_DIV-1; `step` asserts on the wrap.
- FALL, per step:
  - Compute `y = ypos + v` at 13 bits.
  - If `y >= FLOOR`: `ypos <= FLOOR` and `r = v - (v >> BOUNCE_SHIFT)`.
    - If `r < V_MIN`: `v <= 0`, go to REST.
    - Otherwise: `v <= r`, go to RISE.
  - Otherwise: `ypos <= y`, `v <= min(v + GRAVITY, V_MAX)`.
- RISE, per step:
  - `ypos <= (ypos > v) ? ypos - v : 0`.
  - If `v <= GRAVITY`: `v <= 0`, go to FALL.
  - Otherwise: `v <= v - GRAVITY`.
- REST: position is held. On click, go to IDLE; tracking resumes the next cycle.
- `xpos` is frozen in FALL, RISE and REST.
- Clicks in FALL and RISE are ignored. A button held through release does not count as a new click; a fresh edge is required.

## Timing
- Reset values: `xpos=0`, `ypos=0`, `state=IDLE`, `step=0`, `v=0`, tick counter 0, button history 0.
- Reset is honoured at any time, including mid-fall. The block returns to IDLE with no residual velocity.
- IDLE tracking latency: 1 clk from mouse input to `xpos`/`ypos`.
- Click to `state=FALL`: 1 clk after the `mouse_left` edge is sampled (plus the synchroniser delay, if enabled).
- First physics step: TICK_DIV cycles after entering FALL. `xpos`/`ypos`/`state` update in the same cycle as `step`.
- A state change takes effect on a step edge only. Exception: REST→IDLE and IDLE→FALL happen on a click edge.

## Configuration
- `DRAW_RECT_CTL_SYNC_EN`:
  - Defined: `mouse_left` passes through a two-flop synchroniser (reset to 0) before edge detection. Click latency grows by 2 clk.
  - Undefined: `mouse_left` is used directly. This is for inputs already registered in `clk`.

## Test plan
All cases use `TICK_DIV=4`, `GRAVITY=1`, `BOUNCE_SHIFT=1`, `V_MIN=2`, `Y_MAX=600`, `RECT_H=64` (FLOOR=536), with the synchroniser undefined.
- Reset and track: `rst_n` low then high. Mouse at (900, 700) → `xpos=752`, `ypos=536` one clk later; `state=0`.
- Launch: mouse at (100, 0), click → `state=1`. Over steps 1–4, `ypos` takes 0, 1, 3, 6 (v = 0, 1, 2, 3 before each step); `xpos` holds 100.
- Bounce: launch at y=530.
  - Steps 1–4: `ypos` takes 530, 531, 533, 536. The fourth step hits the floor with v=3, so r=2 → RISE with v=2.
  - Next step: `ypos=534`, v=1. The following step: `ypos=533`, v=0 → FALL.
  - The block later reaches REST with `ypos=536`.
- Ignored click: a click during FALL produces no change in `state` or velocity sequence.
- REST exit: click in REST → `state=0` and tracking resumes. Holding the button does not relaunch; release and click again → FALL.
- Async reset mid-fall: `rst_n` low between clock edges → `state=0`, `ypos=0` immediately.
